// File: rtl/count_ctrl_pkg.sv
// Shared types and width helpers for the counter enable control stage.
package count_ctrl_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_TICK_DIV        = 4;

    typedef enum logic [1:0] {
        DB_LOW,
        DB_RISE,
        DB_HIGH,
        DB_FALL
    } db_state_t;

    // Counter width that never collapses to zero bits for a modulus of 1.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces a raw push-button; reports accepted level changes.
module btn_debounce
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press,
    output logic flip,
    output logic level
);

    localparam int CNT_W = width_min1(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             btn_s;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            btn_s  <= 1'b0;
            state  <= DB_LOW;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            btn_s  <= sync_a;
            state  <= state_next;
            db_cnt <= cnt_next;
            press  <= flip && !level;
        end
    end

    // flip marks the edge at which a new level is accepted, in either direction.
    always_comb begin
        state_next = state;
        cnt_next   = db_cnt;
        flip       = 1'b0;
        unique case (state)
            DB_LOW: begin
                if (btn_s) begin
                    state_next = DB_RISE;
                    cnt_next   = '0;
                end
            end
            DB_RISE: begin
                if (!btn_s) begin
                    state_next = DB_LOW;
                end else if (db_cnt == CNT_LAST) begin
                    state_next = DB_HIGH;
                    flip       = 1'b1;
                end else begin
                    cnt_next = db_cnt + 1'b1;
                end
            end
            DB_HIGH: begin
                if (!btn_s) begin
                    state_next = DB_FALL;
                    cnt_next   = '0;
                end
            end
            DB_FALL: begin
                if (btn_s) begin
                    state_next = DB_HIGH;
                end else if (db_cnt == CNT_LAST) begin
                    state_next = DB_LOW;
                    flip       = 1'b1;
                end else begin
                    cnt_next = db_cnt + 1'b1;
                end
            end
            default: state_next = DB_LOW;
        endcase
    end

    assign level = (state == DB_HIGH) || (state == DB_FALL);

endmodule

// File: rtl/count_enable_ctrl.sv
// Start/stop run control with a prescaled one-cycle enable for the counter.
module count_enable_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic stop,
    output logic enable,
    output logic running,
    output logic press
);

    localparam int DIV_W = width_min1(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic             flip;
    logic             level;
    logic             toggle;
    logic             running_next;
    logic [DIV_W-1:0] div;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press),
        .flip  (flip),
        .level (level)
    );

    // Only an accepted rise (level currently low) counts as a press.
    assign toggle = flip && !level;

    always_comb begin
        running_next = running;
        if (stop) begin
            running_next = 1'b0;
        end else if (toggle) begin
            running_next = !running;
        end
    end

    // div only advances while running before and after the edge, so it starts
    // from 0 on a start and clears on the same edge as a stop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            div     <= '0;
        end else begin
            running <= running_next;
            if (running && running_next) begin
                div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            end else begin
                div <= '0;
            end
        end
    end

    assign enable = running && (div == DIV_LAST);

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Scoreboard bench: a streak-based reference model queues expected outputs per edge.
module tb_count_enable_ctrl;

    localparam int DB = 4;
    localparam int TD = 4;

    typedef struct packed {
        logic en;
        logic run;
        logic prs;
    } exp_t;

    bit   clk;
    logic reset = 1'b1;
    logic btn   = 1'b0;
    logic stop  = 1'b0;
    logic enable;
    logic running;
    logic press;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    bit m_s1, m_s2, m_lvl, m_run;
    int m_streak, m_ph;

    count_enable_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV(TD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .stop    (stop),
        .enable  (enable),
        .running (running),
        .press   (press)
    );

    always #40 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic b, input logic s, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            btn  = b;
            stop = s;
        end
    endtask

    function automatic void model_clear();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
        m_streak = 0; m_ph = 0;
    endfunction

    // Acceptance happens on the (DB+1)-th consecutive edge that sees the
    // synchronized button differ from the accepted level.
    always @(posedge clk) begin
        exp_t e;
        bit   accept;
        bit   run_new;
        e = '0;
        if (!reset) begin
            model_clear();
        end else begin
            accept = 0;
            if (m_s2 != m_lvl) begin
                m_streak++;
                if (m_streak == DB + 1) begin
                    m_lvl    = !m_lvl;
                    m_streak = 0;
                    accept   = m_lvl;
                end
            end else begin
                m_streak = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
            run_new = stop ? 1'b0 : (accept ? !m_run : m_run);
            if (run_new && m_run) m_ph++;
            else m_ph = 0;
            m_run = run_new;
            e.en  = m_run && ((m_ph % TD) == TD - 1);
            e.run = m_run;
            e.prs = accept;
        end
        sb.push_back(e);
    end

    always @(negedge reset) begin
        model_clear();
        sb.delete();
        if (clk) sb.push_back('0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() == 0) begin
            check_output("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_output("enable", enable, e.en);
            check_output("running", running, e.run);
            check_output("press", press, e.prs);
        end
    end

    initial begin
        #(80 * 3000);
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_run;
        int first_en;
        int found;
        int press_edge;

        // Reset held with the button toggling underneath.
        #5  reset = 1'b0;
        #10 btn = 1'b1;
        #10 check_output("rst_enable", enable, 0);
        check_output("rst_running", running, 0);
        check_output("rst_press", press, 0);
        #10 btn = 1'b0;
        #20 btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(0, 0, 4);

        // Bounce: no dropout-free run long enough to accept.
        apply_stimulus(1, 0, 2);
        apply_stimulus(0, 0, 1);
        apply_stimulus(1, 0, 2);
        apply_stimulus(0, 0, 10);
        check_output("bounce_running", running, 0);

        // Clean press: running at edge 7, first enable after edge 10.
        @(negedge clk);
        btn = 1'b1;
        first_run = 0;
        first_en  = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (running && first_run == 0) first_run = n;
            if (enable && first_en == 0) first_en = n;
        end
        check_output("run_edge", first_run, 7);
        check_output("en_edge", first_en, 10);
        apply_stimulus(0, 0, 10);
        check_output("release_running", running, 1);

        // Second press stops the run.
        apply_stimulus(1, 0, 10);
        check_output("second_running", running, 0);
        apply_stimulus(0, 0, 10);

        // Stop in the same cycle as an accepted press wins.
        apply_stimulus(1, 0, 1);
        apply_stimulus(1, 0, 5);
        apply_stimulus(1, 1, 1);
        apply_stimulus(1, 0, 6);
        check_output("stop_prio_running", running, 0);
        apply_stimulus(0, 0, 10);

        // Stop pulse while running.
        apply_stimulus(1, 0, 12);
        check_output("restart_running", running, 1);
        apply_stimulus(1, 1, 1);
        @(posedge clk);
        #1;
        check_output("stop_running", running, 0);
        apply_stimulus(1, 0, 8);
        apply_stimulus(0, 0, 10);

        // Reset between enable pulses, button held through release.
        apply_stimulus(1, 0, 12);
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (enable) begin
                found = 1;
                break;
            end
        end
        check_output("en_wait", found, 1);
        @(posedge clk);
        #10 reset = 1'b0;
        #1;
        check_output("midrst_enable", enable, 0);
        check_output("midrst_running", running, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        press_edge = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (press) begin
                press_edge = n;
                break;
            end
        end
        check_output("post_rst_press_edge", press_edge, 7);
        apply_stimulus(0, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
